// File: rtl/lsu_ctrl.sv
// Load/store unit between the memory stage and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    // state | meaning
    // IDLE  | accepting a request
    // READ  | fetching the addressed word into rbuf
    // WRITE | single-cycle memory write
    // RESP  | presenting the response until taken
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rbuf;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, merged;

    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rbuf    <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == READ)
                rbuf <= mem_rd;
        end
    end

    assign mem_addr = {addr_q[31:2], 2'b00};

    // Little-endian lane selection and merge, shared by load and store paths
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = rbuf[7:0];
            2'd1: byte_sel = rbuf[15:8];
            2'd2: byte_sel = rbuf[23:16];
            2'd3: byte_sel = rbuf[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? rbuf[31:16] : rbuf[15:0];

        load_data = rbuf;
        if (size_q == 2'b00)
            load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        else if (size_q == 2'b01)
            load_data = {{16{~uns_q & half_sel[15]}}, half_sel};

        merged = wdata_q;
        if (size_q == 2'b00) begin
            merged = rbuf;
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = rbuf;
            endcase
        end else if (size_q == 2'b01) begin
            merged = rbuf;
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (!req_we || req_size != 2'b10)
                        state_nx = READ;
                    else
                        state_nx = WRITE;
                end
            end
            READ:  state_nx = we_q ? WRITE : RESP;
            WRITE: begin
                mem_we   = 1'b1;
                mem_wd   = merged;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : load_data;
                if (resp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
